// File: rtl/lock_reset_seq.sv
// lock_reset_seq: multi-channel lock synchroniser and ordered reset sequencer.
// Each raw lock input is synchronised into clk. Once all locks have been stable
// for HOLD_CYCLES, the per-channel resets are released in order (bit 0 first),
// GAP_CYCLES apart. Any lock loss during release or run re-asserts every reset,
// pulses lost_stb and bumps a saturating loss counter.
// Optional feature macro: LOCK_RESET_SEQ_SOFT_RST_EN adds a synchronous soft_rst
// input that restarts the sequence without counting a loss.
module lock_reset_seq #(
  parameter int CHANNELS    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 1024,
  parameter int GAP_CYCLES  = 16,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] locked_in,
`ifdef LOCK_RESET_SEQ_SOFT_RST_EN
  input  logic                soft_rst,
`endif
  output logic                all_locked,
  output logic [CHANNELS-1:0] rst_out,
  output logic                ready,
  output logic                lost_stb,
  output logic [CNT_W-1:0]    lost_cnt
);

  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = $clog2(CHANNELS + 1);

  localparam logic [CW-1:0]       HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]       GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0]       IDX_DONE  = IW'(CHANNELS);
  localparam logic [CHANNELS-1:0] ALL_ONES  = {CHANNELS{1'b1}};
  localparam logic [CHANNELS-1:0] CH_ONE    = CHANNELS'(1);

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_HOLD,
    ST_RELEASE,
    ST_RUN,
    ST_LOST
  } state_t;

  state_t                state_reg;
  logic [CW-1:0]         cnt_reg;
  logic [IW-1:0]         idx_reg;
  logic [CHANNELS-1:0]   rst_out_reg;
  logic                  ready_reg;
  logic                  lost_stb_reg;
  logic [CNT_W-1:0]      lost_cnt_reg;
  logic                  all_locked_reg;
  logic [CHANNELS-1:0]   synced;
  logic                  soft_req;
  logic                  loss_event;

  // Per-channel synchroniser chains; the last stage is the clk-domain lock bit.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_sync
    logic [SYNC_STAGES-1:0] sync_reg;

    // Shift the raw lock bit through SYNC_STAGES flops.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_reg <= '0;
      end else begin
        sync_reg <= {sync_reg[SYNC_STAGES-2:0], locked_in[gi]};
      end
    end

    assign synced[gi] = sync_reg[SYNC_STAGES-1];
  end

  // Register the AND of all synchronised locks; the FSM only ever looks at this.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      all_locked_reg <= 1'b0;
    end else begin
      all_locked_reg <= &synced;
    end
  end

`ifdef LOCK_RESET_SEQ_SOFT_RST_EN
  assign soft_req = soft_rst;
`else
  assign soft_req = 1'b0;
`endif

  // A loss only counts once at least one channel has been released; soft reset wins.
  assign loss_event = ((state_reg == ST_RELEASE) || (state_reg == ST_RUN)) &&
                      !all_locked_reg && !soft_req;

  // Sequencer FSM with registered reset, ready and loss-reporting outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_WAIT;
      cnt_reg      <= '0;
      idx_reg      <= '0;
      rst_out_reg  <= ALL_ONES;
      ready_reg    <= 1'b0;
      lost_stb_reg <= 1'b0;
      lost_cnt_reg <= '0;
    end else begin
      lost_stb_reg <= 1'b0;
      if (soft_req) begin
        state_reg   <= ST_WAIT;
        cnt_reg     <= '0;
        idx_reg     <= '0;
        rst_out_reg <= ALL_ONES;
        ready_reg   <= 1'b0;
      end else if (loss_event) begin
        state_reg    <= ST_LOST;
        cnt_reg      <= '0;
        idx_reg      <= '0;
        rst_out_reg  <= ALL_ONES;
        ready_reg    <= 1'b0;
        lost_stb_reg <= 1'b1;
        if (lost_cnt_reg != {CNT_W{1'b1}}) begin
          lost_cnt_reg <= lost_cnt_reg + CNT_W'(1);
        end
      end else begin
        case (state_reg)
          ST_WAIT: begin
            rst_out_reg <= ALL_ONES;
            ready_reg   <= 1'b0;
            idx_reg     <= '0;
            cnt_reg     <= '0;
            if (all_locked_reg) begin
              // The entry edge already counts as the first stable cycle.
              if (HOLD_LAST == '0) begin
                state_reg   <= ST_RELEASE;
                rst_out_reg <= ALL_ONES & ~CH_ONE;
                idx_reg     <= IW'(1);
              end else begin
                state_reg <= ST_HOLD;
                cnt_reg   <= CW'(1);
              end
            end
          end
          ST_HOLD: begin
            if (!all_locked_reg) begin
              state_reg <= ST_WAIT;
              cnt_reg   <= '0;
            end else if (cnt_reg == HOLD_LAST) begin
              state_reg   <= ST_RELEASE;
              rst_out_reg <= rst_out_reg & ~CH_ONE;
              idx_reg     <= IW'(1);
              cnt_reg     <= '0;
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end
          ST_RELEASE: begin
            if (idx_reg == IDX_DONE) begin
              state_reg <= ST_RUN;
              ready_reg <= 1'b1;
            end else if (cnt_reg == GAP_LAST) begin
              rst_out_reg <= rst_out_reg & ~(CH_ONE << idx_reg);
              idx_reg     <= idx_reg + IW'(1);
              cnt_reg     <= '0;
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end
          ST_RUN: begin
            rst_out_reg <= '0;
            ready_reg   <= 1'b1;
          end
          ST_LOST: begin
            state_reg <= ST_WAIT;
          end
          default: begin
            state_reg   <= ST_WAIT;
            rst_out_reg <= ALL_ONES;
            ready_reg   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign all_locked = all_locked_reg;
  assign rst_out    = rst_out_reg;
  assign ready      = ready_reg;
  assign lost_stb   = lost_stb_reg;
  assign lost_cnt   = lost_cnt_reg;

endmodule

// File: tb/tb_lock_reset_seq.sv
// Directed bench for lock_reset_seq: a vector table for the power-up, loss and
// re-lock sequence, plus hand-written sequences for saturation, async reset,
// HOLD interruption, loss racing the final release and (optionally) soft reset.
// A second instance with CNT_W=2 shares the stimulus to exercise saturation.
module tb_lock_reset_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] locked_in = 2'b00;
`ifdef LOCK_RESET_SEQ_SOFT_RST_EN
  logic       soft_rst = 1'b0;
`endif

  logic       al_a, rdy_a, stb_a;
  logic [1:0] ro_a;
  logic [7:0] cnt_a;
  logic       al_b, rdy_b, stb_b;
  logic [1:0] ro_b;
  logic [1:0] cnt_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lock_reset_seq #(
    .CHANNELS(2), .SYNC_STAGES(2), .HOLD_CYCLES(8), .GAP_CYCLES(4), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .locked_in(locked_in),
`ifdef LOCK_RESET_SEQ_SOFT_RST_EN
    .soft_rst(soft_rst),
`endif
    .all_locked(al_a), .rst_out(ro_a), .ready(rdy_a),
    .lost_stb(stb_a), .lost_cnt(cnt_a)
  );

  lock_reset_seq #(
    .CHANNELS(2), .SYNC_STAGES(2), .HOLD_CYCLES(8), .GAP_CYCLES(4), .CNT_W(2)
  ) dut_sat (
    .clk(clk), .rst(rst), .locked_in(locked_in),
`ifdef LOCK_RESET_SEQ_SOFT_RST_EN
    .soft_rst(soft_rst),
`endif
    .all_locked(al_b), .rst_out(ro_b), .ready(rdy_b),
    .lost_stb(stb_b), .lost_cnt(cnt_b)
  );

  typedef struct {
    logic [1:0] li;
    int         adv;
    logic       al;
    logic [1:0] ro;
    logic       rdy;
    logic       stb;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[20];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic al, input logic [1:0] ro,
                             input logic rdy, input logic stb,
                             input logic [7:0] ca, input logic [1:0] cb);
    check({tag, ".all_locked"}, 32'(al_a), 32'(al));
    check({tag, ".rst_out"}, 32'(ro_a), 32'(ro));
    check({tag, ".ready"}, 32'(rdy_a), 32'(rdy));
    check({tag, ".lost_stb"}, 32'(stb_a), 32'(stb));
    check({tag, ".lost_cnt"}, 32'(cnt_a), 32'(ca));
    check({tag, ".sat_rst_out"}, 32'(ro_b), 32'(ro));
    check({tag, ".sat_lost_stb"}, 32'(stb_b), 32'(stb));
    check({tag, ".sat_lost_cnt"}, 32'(cnt_b), 32'(cb));
  endtask

  // Drop locks from RUN and expect the loss on the 4th edge, counted once.
  task automatic do_loss(input logic [1:0] drop, input logic [7:0] exp_a, input logic [1:0] exp_b);
    int seen_at;
    seen_at = -1;
    locked_in = drop;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (stb_a === 1'b1) begin
        seen_at = i;
        break;
      end
    end
    check("loss_latency", 32'(seen_at), 32'd4);
    if (seen_at > 0) check_state("loss", 1'b0, 2'b11, 1'b0, 1'b1, exp_a, exp_b);
    tick();
    check("stb_one_cycle", 32'(stb_a), 32'd0);
    check("sat_stb_one_cycle", 32'(stb_b), 32'd0);
    repeat (4) tick();
    $display("loss drop=%b lost_cnt=%0d sat_lost_cnt=%0d", drop, cnt_a, cnt_b);
  endtask

  // Re-lock from WAIT and expect ready on the 16th edge, same as power-up.
  task automatic relock_to_run(input string tag);
    int got;
    got = -1;
    locked_in = 2'b11;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (rdy_a === 1'b1) begin
        got = i;
        break;
      end
    end
    check({tag, ".edges_to_ready"}, 32'(got), 32'd16);
    check({tag, ".rst_out"}, 32'(ro_a), 32'd0);
    $display("relock %s ready after %0d edges", tag, got);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    logic [1:0] exp_ro;
    logic       exp_al;

    // li, adv, al, rst_out, ready, lost_stb, lost_cnt  (edge count after the row)
    vecs[0]  = '{2'b11, 2,  1'b0, 2'b11, 1'b0, 1'b0, 8'd0}; // e2
    vecs[1]  = '{2'b11, 1,  1'b1, 2'b11, 1'b0, 1'b0, 8'd0}; // e3 all_locked rises
    vecs[2]  = '{2'b11, 7,  1'b1, 2'b11, 1'b0, 1'b0, 8'd0}; // e10
    vecs[3]  = '{2'b11, 1,  1'b1, 2'b10, 1'b0, 1'b0, 8'd0}; // e11 ch0 released
    vecs[4]  = '{2'b11, 3,  1'b1, 2'b10, 1'b0, 1'b0, 8'd0}; // e14
    vecs[5]  = '{2'b11, 1,  1'b1, 2'b00, 1'b0, 1'b0, 8'd0}; // e15 ch1 released
    vecs[6]  = '{2'b11, 1,  1'b1, 2'b00, 1'b1, 1'b0, 8'd0}; // e16 ready
    vecs[7]  = '{2'b11, 5,  1'b1, 2'b00, 1'b1, 1'b0, 8'd0}; // e21
    vecs[8]  = '{2'b10, 2,  1'b1, 2'b00, 1'b1, 1'b0, 8'd0}; // e23 drop ch0
    vecs[9]  = '{2'b10, 1,  1'b0, 2'b00, 1'b1, 1'b0, 8'd0}; // e24
    vecs[10] = '{2'b10, 1,  1'b0, 2'b11, 1'b0, 1'b1, 8'd1}; // e25 loss
    vecs[11] = '{2'b10, 1,  1'b0, 2'b11, 1'b0, 1'b0, 8'd1}; // e26
    vecs[12] = '{2'b10, 15, 1'b0, 2'b11, 1'b0, 1'b0, 8'd1}; // e41 (20 cycles low)
    vecs[13] = '{2'b11, 2,  1'b0, 2'b11, 1'b0, 1'b0, 8'd1}; // e43 re-lock
    vecs[14] = '{2'b11, 1,  1'b1, 2'b11, 1'b0, 1'b0, 8'd1}; // e44
    vecs[15] = '{2'b11, 7,  1'b1, 2'b11, 1'b0, 1'b0, 8'd1}; // e51
    vecs[16] = '{2'b11, 1,  1'b1, 2'b10, 1'b0, 1'b0, 8'd1}; // e52
    vecs[17] = '{2'b11, 3,  1'b1, 2'b10, 1'b0, 1'b0, 8'd1}; // e55
    vecs[18] = '{2'b11, 1,  1'b1, 2'b00, 1'b0, 1'b0, 8'd1}; // e56
    vecs[19] = '{2'b11, 1,  1'b1, 2'b00, 1'b1, 1'b0, 8'd1}; // e57

    // Reset state
    rst = 1'b1;
    locked_in = 2'b00;
    repeat (3) tick();
    check_state("reset", 1'b0, 2'b11, 1'b0, 1'b0, 8'd0, 2'd0);

    // Power-up, loss and re-lock from the vector table
    rst = 1'b0;
    locked_in = 2'b11;
    for (int r = 0; r < 20; r++) begin
      locked_in = vecs[r].li;
      repeat (vecs[r].adv) tick();
      check_state($sformatf("vec%0d", r), vecs[r].al, vecs[r].ro, vecs[r].rdy,
                  vecs[r].stb, vecs[r].cnt, vecs[r].cnt[1:0]);
      $display("vec %0d li=%b rst_out=%b ready=%b lost_cnt=%0d", r, vecs[r].li, ro_a, rdy_a, cnt_a);
    end

    // Saturation: four more losses from RUN (sat counter reads 2,3,3,3)
    do_loss(2'b01, 8'd2, 2'd2);
    relock_to_run("relock2");
    do_loss(2'b10, 8'd3, 2'd3);
    relock_to_run("relock3");
    do_loss(2'b00, 8'd4, 2'd3);
    relock_to_run("relock4");
    do_loss(2'b01, 8'd5, 2'd3);

    // Async reset between the two channel releases
    locked_in = 2'b11;
    got = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (ro_a === 2'b10) begin
        got = i;
        break;
      end
    end
    check("mid_release_edge", 32'(got), 32'd11);
    tick();
    #2 rst = 1'b1;
    #1;
    check_state("async_rst", 1'b0, 2'b11, 1'b0, 1'b0, 8'd0, 2'd0);
    $display("async rst mid-release rst_out=%b lost_cnt=%0d", ro_a, cnt_a);

    // Restart from WAIT with a 3-cycle drop of ch1 during HOLD
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int e = 1; e <= 25; e++) begin
      locked_in = (e >= 6 && e <= 8) ? 2'b01 : 2'b11;
      tick();
      exp_ro = (e >= 23) ? 2'b00 : ((e >= 19) ? 2'b10 : 2'b11);
      exp_al = ((e >= 3 && e <= 7) || e >= 11) ? 1'b1 : 1'b0;
      check_state($sformatf("hold_glitch_e%0d", e), exp_al, exp_ro, (e >= 24) ? 1'b1 : 1'b0,
                  1'b0, 8'd0, 2'd0);
    end
    $display("hold glitch sequence ready=%b lost_cnt=%0d", rdy_a, cnt_a);

    // Loss arriving on the same edge as the final release
    do_loss(2'b00, 8'd1, 2'd1);
    locked_in = 2'b11;
    for (int e = 1; e <= 15; e++) begin
      if (e == 12) locked_in = 2'b01;
      tick();
      if (e == 14) check("race_pre.rst_out", 32'(ro_a), 32'h2);
      if (e == 15) check_state("race_loss_wins", 1'b0, 2'b11, 1'b0, 1'b1, 8'd2, 2'd2);
    end
    $display("race loss vs final release rst_out=%b lost_cnt=%0d", ro_a, cnt_a);
    repeat (5) tick();
    relock_to_run("relock_after_race");

`ifdef LOCK_RESET_SEQ_SOFT_RST_EN
    // Soft reset pulse in RUN: not a loss, full sequence repeats
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    check_state("soft_rst", 1'b1, 2'b11, 1'b0, 1'b0, 8'd2, 2'd2);
    got = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (stb_a === 1'b1) check("soft_no_stb", 32'(stb_a), 32'd0);
      if (rdy_a === 1'b1) begin
        got = i;
        break;
      end
    end
    check("soft_edges_to_ready", 32'(got), 32'd13);
    check("soft_cnt_kept", 32'(cnt_a), 32'd2);
    $display("soft rst ready after %0d edges", got);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
